// File: rtl/seq_det_pkg.sv
// Shared state encodings and the 1101 Moore next-state function for the channel contexts.
// Pure definitions, no timing or flow control of their own.
package seq_det_pkg;

    typedef enum logic [2:0] {
        GN      = 3'd0,
        GOT1    = 3'd1,
        GOT11   = 3'd2,
        GOT110  = 3'd3,
        GOT1101 = 3'd4
    } det_state_t;

    localparam int STW = 3;

    // Overlapping detection: after a hit the trailing "1" is reused as a fresh prefix.
    function automatic det_state_t seq_det_next(input logic [STW-1:0] state, input logic b);
        det_state_t nxt;
        case (state)
            GN:      nxt = b ? GOT1  : GN;
            GOT1:    nxt = b ? GOT11 : GN;
            GOT11:   nxt = b ? GOT11 : GOT110;
            GOT110:  nxt = b ? GOT1101 : GN;
            GOT1101: nxt = b ? GOT11 : GN;
            default: nxt = GN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_det_rr_sched_if.sv
// Channel-side handshake plus detector result bus for seq_det_rr_sched.
// Valid/ready on the channel side; the result side has no backpressure.
interface seq_det_rr_sched_if #(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int CNTW = 16
);
    logic [NCH-1:0]  ch_valid;
    logic [NCH-1:0]  ch_bit;
    logic [NCH-1:0]  ch_ready;
    logic [NCH-1:0]  ch_clear;
    logic            det_valid;
    logic [CHW-1:0]  det_ch;
    logic [2:0]      det_state;
    logic            det_hit;
    logic [CNTW-1:0] hit_cnt;

    modport master (
        output ch_valid, ch_bit, ch_clear,
        input  ch_ready, det_valid, det_ch, det_state, det_hit, hit_cnt
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clear,
        output ch_ready, det_valid, det_ch, det_state, det_hit, hit_cnt
    );
endinterface

// File: rtl/seq_det_rr_sched_arb.sv
// Round-robin arbiter: combinational one-hot grant from req and the pointer it owns.
// Pointer moves past the granted channel only when advance is high; grant is zero in reset.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    input  logic [CHW-1:0] gnt_idx,
    output logic [NCH-1:0] gnt
);

    logic [CHW-1:0] ptr_q;
    logic [CHW-1:0] ptr_d;
    logic [NCH-1:0] upper_mask;
    logic [NCH-1:0] req_hi;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            upper_mask[i] = (i >= int'(ptr_q));
        end
    end

    // Requests at or above the pointer win; otherwise wrap to the lowest request overall.
    always_comb begin
        req_hi = req & upper_mask;
        gnt    = '0;
        if (rst) begin
            if (req_hi != '0) begin
                gnt = req_hi & (-req_hi);
            end else begin
                gnt = req & (-req);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_rr_sched.sv
// Shares one 1101 Moore detector across NCH serial channels; one granted bit per cycle, result one cycle later.
// Channels see valid/ready (clear suppresses eligibility); results are pushed with no backpressure.
module seq_det_rr_sched
    import seq_det_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_rr_sched_if.slave  bus
);

    det_state_t     ctx_q [NCH];
    det_state_t     ctx_d [NCH];

    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic           xfer;
    logic [CHW-1:0] gnt_idx;
    det_state_t     cur_st;
    det_state_t     nxt_st;

    logic            det_valid_q, det_valid_d;
    logic [CHW-1:0]  det_ch_q,    det_ch_d;
    det_state_t      det_state_q, det_state_d;
    logic            det_hit_q,   det_hit_d;
    logic [CNTW-1:0] hit_cnt_q,   hit_cnt_d;

    // A channel being cleared cannot be granted, so its pending bit stays with the source.
    assign elig = bus.ch_valid & ~bus.ch_clear;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (xfer),
        .gnt_idx (gnt_idx),
        .gnt     (gnt)
    );

    assign xfer         = |gnt;
    assign bus.ch_ready = gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                gnt_idx = CHW'(i);
            end
        end
    end

    assign cur_st = ctx_q[gnt_idx];
    assign nxt_st = seq_det_next(cur_st, bus.ch_bit[gnt_idx]);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst) begin
                ctx_q[i] <= GN;
            end else begin
                ctx_q[i] <= ctx_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctx_d[i] = ctx_q[i];
            if (bus.ch_clear[i]) begin
                ctx_d[i] = GN;
            end else if (gnt[i]) begin
                ctx_d[i] = nxt_st;
            end
        end
    end

    always_comb begin
        det_valid_d = xfer;
        det_ch_d    = det_ch_q;
        det_state_d = det_state_q;
        det_hit_d   = det_hit_q;
        hit_cnt_d   = hit_cnt_q;
        if (xfer) begin
            det_ch_d    = gnt_idx;
            det_state_d = nxt_st;
            det_hit_d   = (nxt_st == GOT1101);
            if ((nxt_st == GOT1101) && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_state_q <= GN;
            det_hit_q   <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_state_q <= det_state_d;
            det_hit_q   <= det_hit_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.det_state = det_state_q;
    assign bus.det_hit   = det_hit_q;
    assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed bench for seq_det_rr_sched with NCH=4 and a 2-bit hit counter so saturation is reachable.
module tb_seq_det_rr_sched;

    logic clk;
    logic rst;

    int tests    = 0;
    int fails    = 0;
    int hits_exp = 0;

    logic [3:0] seq0;
    logic [2:0] st0 [4];

    seq_det_rr_sched_if #(.NCH(4), .CHW(2), .CNTW(2)) bus ();

    seq_det_rr_sched #(.NCH(4), .CHW(2), .CNTW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One lone bit on channel ch; checks the grant, then the registered result and counter.
    task automatic xfer1(input int ch, input logic b, input logic [2:0] exp_st);
        bus.ch_valid     = '0;
        bus.ch_bit       = '0;
        bus.ch_clear     = '0;
        bus.ch_valid[ch] = 1'b1;
        bus.ch_bit[ch]   = b;
        #1;
        chk("lone_ready", 32'(bus.ch_ready), 32'(1) << ch);
        tick();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        if (exp_st == 3'd4 && hits_exp < 3) hits_exp++;
        chk("lone_det_valid", 32'(bus.det_valid), 32'd1);
        chk("lone_det_ch",    32'(bus.det_ch),    32'(ch));
        chk("lone_det_state", 32'(bus.det_state), 32'(exp_st));
        chk("lone_det_hit",   32'(bus.det_hit),   32'(exp_st == 3'd4));
        chk("lone_hit_cnt",   32'(bus.hit_cnt),   32'(hits_exp));
    endtask

    task automatic check_reset_outputs();
        chk("rst_det_valid", 32'(bus.det_valid), 32'd0);
        chk("rst_det_ch",    32'(bus.det_ch),    32'd0);
        chk("rst_det_state", 32'(bus.det_state), 32'd0);
        chk("rst_det_hit",   32'(bus.det_hit),   32'd0);
        chk("rst_hit_cnt",   32'(bus.hit_cnt),   32'd0);
    endtask

    initial begin
        seq0   = 4'b1011;
        st0[0] = 3'd1;
        st0[1] = 3'd2;
        st0[2] = 3'd3;
        st0[3] = 3'd4;

        // Power-up reset with every channel requesting: no grants allowed.
        rst          = 1'b0;
        bus.ch_valid = 4'hF;
        bus.ch_bit   = 4'hF;
        bus.ch_clear = 4'h0;
        #2;
        chk("rst_ready", 32'(bus.ch_ready), 32'd0);
        tick();
        check_reset_outputs();
        rst          = 1'b1;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;

        // Channel 2 alone: 1,1,0,1,1,0,1 hits on 4th and 7th bit.
        xfer1(2, 1'b1, 3'd1);
        xfer1(2, 1'b1, 3'd2);
        xfer1(2, 1'b0, 3'd3);
        xfer1(2, 1'b1, 3'd4);
        xfer1(2, 1'b1, 3'd2);
        xfer1(2, 1'b0, 3'd3);
        xfer1(2, 1'b1, 3'd4);
        tick();
        chk("idle_det_valid", 32'(bus.det_valid), 32'd0);
        chk("idle_det_ch",    32'(bus.det_ch),    32'd2);
        chk("idle_det_state", 32'(bus.det_state), 32'd4);
        chk("idle_det_hit",   32'(bus.det_hit),   32'd1);

        // Reset mid-stream with channel 0 sitting in GOT110.
        xfer1(0, 1'b1, 3'd1);
        xfer1(0, 1'b1, 3'd2);
        xfer1(0, 1'b0, 3'd3);
        rst            = 1'b0;
        bus.ch_valid   = 4'b0001;
        bus.ch_bit     = 4'b0001;
        #1;
        chk("midrst_ready", 32'(bus.ch_ready), 32'd0);
        tick();
        check_reset_outputs();
        rst      = 1'b1;
        hits_exp = 0;
        xfer1(0, 1'b1, 3'd1);

        // Five hits through a 2-bit counter: 1,2,3,3,3.
        xfer1(2, 1'b1, 3'd1);
        xfer1(2, 1'b1, 3'd2);
        xfer1(2, 1'b0, 3'd3);
        xfer1(2, 1'b1, 3'd4);
        for (int r = 0; r < 4; r++) begin
            xfer1(2, 1'b1, 3'd2);
            xfer1(2, 1'b0, 3'd3);
            xfer1(2, 1'b1, 3'd4);
        end
        chk("sat_hit_cnt", 32'(bus.hit_cnt), 32'd3);

        // Fresh reset, then all four channels valid every cycle.
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        hits_exp = 0;
        bus.ch_valid = 4'hF;
        for (int k = 0; k < 16; k++) begin
            bus.ch_bit    = '0;
            bus.ch_bit[0] = seq0[k/4];
            #1;
            chk("ilv_ready", 32'(bus.ch_ready), 32'(1) << (k % 4));
            tick();
            if (k == 12) hits_exp++;
            chk("ilv_det_ch",    32'(bus.det_ch),    32'(k % 4));
            chk("ilv_det_state", 32'(bus.det_state), (k % 4 == 0) ? 32'(st0[k/4]) : 32'd0);
            chk("ilv_det_hit",   32'(bus.det_hit),   32'(k == 12));
            chk("ilv_hit_cnt",   32'(bus.hit_cnt),   32'(hits_exp));
        end

        // Channels 1 and 3 contend; grants must alternate.
        bus.ch_valid = 4'b1010;
        bus.ch_bit   = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fair_ready", 32'(bus.ch_ready), (k % 2 == 0) ? 32'd2 : 32'd8);
            tick();
            chk("fair_det_ch", 32'(bus.det_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
        end
        bus.ch_valid = '0;

        // Clear collides with a pending bit on channel 1; channel 0 (in GOT1101) is cleared too.
        xfer1(1, 1'b1, 3'd1);
        xfer1(1, 1'b1, 3'd2);
        xfer1(1, 1'b0, 3'd3);
        bus.ch_valid = 4'b1010;
        bus.ch_bit   = 4'b1010;
        bus.ch_clear = 4'b0011;
        #1;
        chk("clr_ready", 32'(bus.ch_ready), 32'd8);
        tick();
        chk("clr_det_ch",    32'(bus.det_ch),    32'd3);
        chk("clr_det_state", 32'(bus.det_state), 32'd1);
        bus.ch_clear = '0;
        xfer1(1, 1'b1, 3'd1);
        xfer1(0, 1'b1, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
